// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX->MEM stage: registers ALU results, runs one req/ack data access, formats loads.
// Optional macro EX_MEM_MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of forcing alignment.
module ex_mem_stage #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_res,
    input  logic              ex_comp_res,
    input  logic [DATA_W-1:0] ex_rs2_data,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic [2:0]        ex_funct3,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ex_stall,
`ifdef EX_MEM_MISALIGN_TRAP_EN
    output logic              misalign,
`endif
    output logic              wb_valid,
    output logic              wb_regwrite,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_comp,
    output logic              mem_err
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic [REG_AW-1:0] rd_q;
    logic              regwrite_q;
    logic              comp_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [3:0]        mem_be_q;
    logic              wb_valid_q;
    logic              wb_regwrite_q;
    logic [REG_AW-1:0] wb_rd_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              wb_comp_q;
    logic              mem_err_q;

    logic              accept;
    logic              ex_is_mem;
    logic              ex_is_b;
    logic              ex_is_h;
    logic [3:0]        be_d;
    logic [DATA_W-1:0] wdata_d;
    logic [7:0]        ld_b;
    logic [15:0]       ld_h;
    logic [DATA_W-1:0] ld_data;

    assign ex_stall  = (state_q != S_IDLE);
    assign accept    = ex_valid & ~flush & ~ex_stall;
    assign ex_is_mem = ex_memread | ex_memwrite;
    // funct3[1] set selects a word access, which also covers the reserved 011/110/111 codes
    assign ex_is_b   = ~ex_funct3[1] & ~ex_funct3[0];
    assign ex_is_h   = ~ex_funct3[1] &  ex_funct3[0];

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = ex_rs2_data;
        if (ex_is_b) begin
            be_d    = 4'b0001 << ex_res[1:0];
            wdata_d = {4{ex_rs2_data[7:0]}};
        end else if (ex_is_h) begin
            be_d    = 4'b0011 << {ex_res[1], 1'b0};
            wdata_d = {2{ex_rs2_data[15:0]}};
        end
    end

    always_comb begin
        ld_b    = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_h    = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data = mem_rdata;
        if (!funct3_q[1]) begin
            if (funct3_q[0]) ld_data = {{16{ld_h[15] & ~funct3_q[2]}}, ld_h};
            else             ld_data = {{24{ld_b[7] & ~funct3_q[2]}}, ld_b};
        end
    end

`ifdef EX_MEM_MISALIGN_TRAP_EN
    logic ex_misaligned;
    logic misalign_q;
    assign ex_misaligned = (ex_is_h & ex_res[0]) | (ex_funct3[1] & (ex_res[1:0] != 2'b00));
    assign misalign      = misalign_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            funct3_q      <= '0;
            rd_q          <= '0;
            regwrite_q    <= 1'b0;
            comp_q        <= 1'b0;
            cnt_q         <= '0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            wb_comp_q     <= 1'b0;
            mem_err_q     <= 1'b0;
`ifdef EX_MEM_MISALIGN_TRAP_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            mem_err_q     <= 1'b0;
`ifdef EX_MEM_MISALIGN_TRAP_EN
            misalign_q    <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (accept && !ex_is_mem) begin
                        wb_valid_q    <= 1'b1;
                        wb_regwrite_q <= ex_regwrite;
                        wb_rd_q       <= ex_rd;
                        wb_data_q     <= ex_res;
                        wb_comp_q     <= ex_comp_res;
`ifdef EX_MEM_MISALIGN_TRAP_EN
                    end else if (accept && ex_misaligned) begin
                        misalign_q    <= 1'b1;
                        wb_valid_q    <= 1'b1;
                        wb_rd_q       <= ex_rd;
                        wb_data_q     <= ex_res;
                        wb_comp_q     <= ex_comp_res;
`endif
                    end else if (accept) begin
                        state_q     <= S_REQ;
                        addr_q      <= ex_res;
                        funct3_q    <= ex_funct3;
                        rd_q        <= ex_rd;
                        regwrite_q  <= ex_regwrite & ex_memread;
                        comp_q      <= ex_comp_res;
                        mem_we_q    <= ex_memwrite;
                        mem_wdata_q <= wdata_d;
                        mem_be_q    <= be_d;
                        cnt_q       <= '0;
                    end
                end
                S_REQ: state_q <= S_WAIT;
                S_WAIT: begin
                    // an ack arriving on the final allowed cycle still completes normally
                    if (mem_ack || cnt_q == CNT_LAST) begin
                        state_q       <= S_IDLE;
                        wb_valid_q    <= 1'b1;
                        wb_regwrite_q <= mem_ack & regwrite_q;
                        wb_rd_q       <= rd_q;
                        wb_data_q     <= (mem_ack && !mem_we_q) ? ld_data : addr_q;
                        wb_comp_q     <= comp_q;
                        mem_err_q     <= ~mem_ack;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_req     = (state_q != S_IDLE);
    assign mem_we      = mem_we_q;
    assign mem_addr    = {addr_q[DATA_W-1:2], 2'b00};
    assign mem_wdata   = mem_wdata_q;
    assign mem_be      = mem_be_q;
    assign wb_valid    = wb_valid_q;
    assign wb_regwrite = wb_regwrite_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign wb_comp     = wb_comp_q;
    assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - self-checking bench for ex_mem_stage: vector table, corner sequences, random ops.
module tb_ex_mem_stage;

    localparam int TO = 4;

    logic        clk, rst_n;
    logic        ex_valid, ex_comp_res, ex_regwrite, ex_memread, ex_memwrite, flush;
    logic [31:0] ex_res, ex_rs2_data, mem_rdata;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        mem_ack;
    logic        mem_req, mem_we, ex_stall, wb_valid, wb_regwrite, wb_comp, mem_err;
    logic [31:0] mem_addr, mem_wdata, wb_data;
    logic [3:0]  mem_be;
    logic [4:0]  wb_rd;
`ifdef EX_MEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    ex_mem_stage #(.DATA_W(32), .REG_AW(5), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_res(ex_res), .ex_comp_res(ex_comp_res),
        .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_funct3(ex_funct3), .flush(flush), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ex_stall(ex_stall),
`ifdef EX_MEM_MISALIGN_TRAP_EN
        .misalign(misalign),
`endif
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_comp(wb_comp), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res, rs2, rdata;
        logic [4:0]  rd;
        logic        rw, mr, mw, comp;
        logic [2:0]  f3;
        int          delay;
        logic [3:0]  e_be;
        logic [31:0] e_wdata, e_wb;
    } vec_t;

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [31:0] res, rs2, input logic [4:0] rd, input logic rw, mr, mw,
                                input logic [2:0] f3, input logic [31:0] rdata, input int delay, input logic comp,
                                input logic [3:0] e_be, input logic [31:0] e_wdata, e_wb);
        vec_t v;
        v.res = res; v.rs2 = rs2; v.rd = rd; v.rw = rw; v.mr = mr; v.mw = mw; v.f3 = f3;
        v.rdata = rdata; v.delay = delay; v.comp = comp; v.e_be = e_be; v.e_wdata = e_wdata; v.e_wb = e_wb;
        return v;
    endfunction

    // reference model: access size 1/2/4 bytes from funct3, lanes by plain arithmetic
    function automatic int m_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int off = int'(a % 4);
        if (m_size(f3) == 1) return 4'(1 << off);
        if (m_size(f3) == 2) return 4'(3 << ((off / 2) * 2));
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (m_size(f3) == 1) return (d % 256) * 32'h0101_0101;
        if (m_size(f3) == 2) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int off = int'(a % 4);
        logic [31:0] v;
        if (m_size(f3) == 1) begin
            v = (d >> (8 * off)) % 256;
            if (f3 == 3'b000 && v >= 128) v = v - 32'd256;
        end else if (m_size(f3) == 2) begin
            v = (d >> (16 * (off / 2))) % 65536;
            if (f3 == 3'b001 && v >= 32768) v = v - 32'd65536;
        end else begin
            v = d;
        end
        return v;
    endfunction

`ifdef EX_MEM_MISALIGN_TRAP_EN
    function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
        return (m_size(f3) == 2 && (a % 2) != 0) || (m_size(f3) == 4 && (a % 4) != 0);
    endfunction
`endif

    task automatic drive(input vec_t v);
        ex_valid = 1'b1; flush = 1'b0; ex_res = v.res; ex_rs2_data = v.rs2; ex_rd = v.rd;
        ex_regwrite = v.rw; ex_memread = v.mr; ex_memwrite = v.mw; ex_funct3 = v.f3; ex_comp_res = v.comp;
    endtask

    task automatic run_op(input vec_t v, input string t);
        bit mis = 1'b0;
`ifdef EX_MEM_MISALIGN_TRAP_EN
        mis = (v.mr | v.mw) && m_mis(v.f3, v.res);
`endif
        drive(v);
        step();
        ex_valid = 1'b0;
        if (mis) begin
`ifdef EX_MEM_MISALIGN_TRAP_EN
            chk({t, " mis_req"}, mem_req, 0);
            chk({t, " mis_stall"}, ex_stall, 0);
            chk({t, " mis_pulse"}, misalign, 1);
            chk({t, " mis_wbv"}, wb_valid, 1);
            chk({t, " mis_wbrw"}, wb_regwrite, 0);
`endif
        end else if (v.mr | v.mw) begin
            chk({t, " req"}, mem_req, 1);
            chk({t, " stall"}, ex_stall, 1);
            chk({t, " we"}, mem_we, v.mw);
            chk({t, " addr"}, mem_addr, v.res & 32'hFFFF_FFFC);
            chk({t, " be"}, mem_be, v.e_be);
            if (v.mw) chk({t, " wdata"}, mem_wdata, v.e_wdata);
            step();
            for (int k = 0; k < v.delay && k < TO; k++) begin
                chk({t, " wait_req"}, mem_req, 1);
                chk({t, " wait_wbv"}, wb_valid, 0);
                step();
            end
            if (v.delay < TO) begin
                mem_ack = 1'b1; mem_rdata = v.rdata;
                step();
                mem_ack = 1'b0; mem_rdata = $urandom;
                chk({t, " done_wbv"}, wb_valid, 1);
                chk({t, " done_rd"}, wb_rd, v.rd);
                chk({t, " done_rw"}, wb_regwrite, v.mr & v.rw);
                chk({t, " done_err"}, mem_err, 0);
                if (v.mr) chk({t, " ldata"}, wb_data, v.e_wb);
            end else begin
                chk({t, " to_err"}, mem_err, 1);
                chk({t, " to_wbv"}, wb_valid, 1);
                chk({t, " to_rw"}, wb_regwrite, 0);
            end
            chk({t, " end_req"}, mem_req, 0);
            chk({t, " end_stall"}, ex_stall, 0);
            chk({t, " comp"}, wb_comp, v.comp);
        end else begin
            chk({t, " alu_wbv"}, wb_valid, 1);
            chk({t, " alu_data"}, wb_data, v.e_wb);
            chk({t, " alu_rd"}, wb_rd, v.rd);
            chk({t, " alu_rw"}, wb_regwrite, v.rw);
            chk({t, " alu_comp"}, wb_comp, v.comp);
            chk({t, " alu_stall"}, ex_stall, 0);
        end
        step();
        chk({t, " beat_once"}, wb_valid, 0);
        chk({t, " err_once"}, mem_err, 0);
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        rst_n = 1'b0; ex_valid = 0; flush = 0; ex_res = 0; ex_rs2_data = 0; ex_rd = 0; ex_regwrite = 0;
        ex_memread = 0; ex_memwrite = 0; ex_funct3 = 0; ex_comp_res = 0; mem_ack = 0; mem_rdata = 0;

        //                res           rs2           rd  rw mr mw f3      rdata         dly cmp be       wdata         wb
        tbl.push_back(mk(32'h0000_1234, 32'h0,        5,  1, 0, 0, 3'b000, 32'h0,        0, 1, 4'b0000, 32'h0,        32'h0000_1234));
        tbl.push_back(mk(32'h0000_0103, 32'hAABB_CCDD, 0, 0, 0, 1, 3'b000, 32'h0,        3, 0, 4'b1000, 32'hDDDD_DDDD, 32'h0));
        tbl.push_back(mk(32'h0000_0102, 32'h0,        7,  1, 1, 0, 3'b000, 32'h0080_0000, 0, 1, 4'b0100, 32'h0,        32'hFFFF_FF80));
        tbl.push_back(mk(32'h0000_0102, 32'h0,        8,  1, 1, 0, 3'b101, 32'h0080_0000, 2, 0, 4'b1100, 32'h0,        32'h0000_0080));
        tbl.push_back(mk(32'h0000_0200, 32'h0,        9,  1, 1, 0, 3'b001, 32'h1234_8001, 1, 0, 4'b0011, 32'h0,        32'hFFFF_8001));
        tbl.push_back(mk(32'h0000_03FC, 32'h0,        10, 1, 1, 0, 3'b010, 32'hDEAD_BEEF, 1, 1, 4'b1111, 32'h0,        32'hDEAD_BEEF));
        tbl.push_back(mk(32'h0000_0042, 32'h1111_BEEF, 0, 0, 0, 1, 3'b001, 32'h0,        0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0));
        tbl.push_back(mk(32'h0000_0050, 32'hCAFE_F00D, 0, 1, 0, 1, 3'b010, 32'h0,        2, 1, 4'b1111, 32'hCAFE_F00D, 32'h0));
        tbl.push_back(mk(32'h0000_0101, 32'h0,        11, 1, 1, 0, 3'b100, 32'h0000_F000, 0, 0, 4'b0010, 32'h0,        32'h0000_00F0));
        tbl.push_back(mk(32'h0000_0204, 32'h0,        12, 0, 1, 0, 3'b111, 32'h1357_9BDF, 3, 1, 4'b1111, 32'h0,        32'h1357_9BDF));
        tbl.push_back(mk(32'hFFFF_FFFF, 32'h0,        31, 0, 0, 0, 3'b000, 32'h0,        0, 0, 4'b0000, 32'h0,        32'hFFFF_FFFF));
        tbl.push_back(mk(32'h0000_0400, 32'h0,        13, 1, 1, 0, 3'b010, 32'h0,        TO, 1, 4'b1111, 32'h0,       32'h0));

        repeat (2) @(posedge clk);
        #1;
        chk("rst wb_valid", wb_valid, 0);
        chk("rst mem_req", mem_req, 0);
        chk("rst ex_stall", ex_stall, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_be", mem_be, 0);
        chk("rst wb_data", wb_data, 0);
        chk("rst mem_err", mem_err, 0);
        chk("rst mem_we", mem_we, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < tbl.size(); i++) run_op(tbl[i], $sformatf("vec%0d", i));

        // flush of an op offered in IDLE produces nothing
        drive(mk(32'h55, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        flush = 1'b1;
        step();
        chk("flush_idle wbv", wb_valid, 0);
        ex_memwrite = 1'b1;
        step();
        chk("flush_idle req", mem_req, 0);
        chk("flush_idle stall", ex_stall, 0);
        flush = 1'b0; ex_valid = 1'b0; ex_memwrite = 1'b0;
        step();

        // flush during WAIT; a stalled op is not accepted the cycle WAIT exits
        drive(mk(32'h300, 0, 9, 1, 1, 0, 3'b010, 0, 0, 0, 0, 0, 0));
        step();
        drive(mk(32'h777, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        flush = 1'b1;
        step();
        chk("flushw stall", ex_stall, 1);
        flush = 1'b0;
        step();
        chk("flushw wbv0", wb_valid, 0);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        step();
        mem_ack = 1'b0;
        chk("flushw wbv", wb_valid, 1);
        chk("flushw data", wb_data, 32'h0BAD_F00D);
        chk("flushw rd", wb_rd, 9);
        step();
        ex_valid = 1'b0;
        chk("next wbv", wb_valid, 1);
        chk("next data", wb_data, 32'h777);
        chk("next rd", wb_rd, 3);
        step();

        // reset while waiting for ack
        drive(mk(32'h500, 0, 6, 1, 1, 0, 3'b010, 0, 0, 0, 0, 0, 0));
        step();
        ex_valid = 1'b0;
        step();
        chk("prerst req", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst req", mem_req, 0);
        chk("midrst stall", ex_stall, 0);
        chk("midrst addr", mem_addr, 0);
        chk("midrst be", mem_be, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("postrst wbv", wb_valid, 0);
        chk("postrst req", mem_req, 0);

`ifdef EX_MEM_MISALIGN_TRAP_EN
        run_op(mk(32'h102, 0, 14, 1, 1, 0, 3'b010, 0, 0, 0, 0, 0, 0), "mis_lw");
`endif

        for (int i = 0; i < 60; i++) begin
            int kind = $urandom_range(0, 2);
            logic [31:0] a = $urandom;
            logic [31:0] d = $urandom;
            logic [31:0] r = $urandom;
            logic [2:0] f = 3'($urandom_range(0, 7));
            rv = mk(a, d, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), kind == 1, kind == 2, f, r,
                    $urandom_range(0, TO + 1), 1'($urandom_range(0, 1)), m_be(f, a), m_wdata(f, d),
                    (kind == 1) ? m_load(f, a, r) : a);
            run_op(rv, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
